// File: rtl/rf_write_arbiter_pkg.sv
// Shared core definitions for the register file write path.
package rf_write_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // Architectural zero register: writes to it are dropped everywhere.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One register file write request; the pipeline WB stage reuses this.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small power-of-two FIFO buffering multi-cycle unit results.
module rf_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Pointers wrap naturally because DEPTH is a power of two; a push and a pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale entries are never visible because empty gates the head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between WB and the multi-cycle unit and tracks MC hazards.
module rf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int DATA_W     = rf_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W     = rf_write_arbiter_pkg::ADDR_W,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    input  logic              mc_issue,
    input  logic [ADDR_W-1:0] mc_issue_addr,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              dec_we,
    input  logic [ADDR_W-1:0] dec_dst,
    output logic              stall,
    output logic              RW,
    output logic [ADDR_W-1:0] DA,
    output logic [DATA_W-1:0] BUS_D
);

    import rf_write_arbiter_pkg::*;

    localparam int NREG  = 1 << ADDR_W;
    localparam int AGE_W = $clog2(STARVE_LIM + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIM);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mc_req_t;

    mc_req_t          push_req;
    mc_req_t          head_req;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             wb_req;
    logic [AGE_W-1:0] age;
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_next;

    assign push_req = '{addr: mc_addr, data: mc_data};
    assign mc_ready = rst_n && !full;
    assign push     = mc_valid && mc_ready && (mc_addr != REG_ZERO);
    assign wb_req   = wb_valid && (wb_addr != REG_ZERO);

    rf_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_req),
        .head      (head_req),
        .full      (full),
        .empty     (empty)
    );

    // Write port arbitration: a starved head beats WB, otherwise WB first, then the FIFO fills idle slots.
    always_comb begin
        RW       = 1'b0;
        DA       = '0;
        BUS_D    = '0;
        wb_stall = 1'b0;
        pop      = 1'b0;
        if (rst_n) begin
            if ((age == AGE_MAX) && !empty) begin
                pop      = 1'b1;
                RW       = 1'b1;
                DA       = head_req.addr;
                BUS_D    = head_req.data;
                wb_stall = wb_req;
            end else if (wb_req) begin
                RW    = 1'b1;
                DA    = wb_addr;
                BUS_D = wb_data;
            end else if (!empty) begin
                pop   = 1'b1;
                RW    = 1'b1;
                DA    = head_req.addr;
                BUS_D = head_req.data;
            end
        end
    end

    // Age counts cycles the head has waited without draining, saturating at the starvation limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (empty || pop) begin
            age <= '0;
        end else if (age != AGE_MAX) begin
            age <= age + 1'b1;
        end
    end

    // Scoreboard update: clear on drain first so a same-cycle issue to that register wins.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head_req.addr] = 1'b0;
        if (mc_issue) busy_next[mc_issue_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

    assign stall = rst_n && dec_valid &&
                   (busy[AA] || busy[BA] || (dec_we && busy[dec_dst]) || (mc_issue && full));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scoreboard bench for rf_write_arbiter.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        mc_issue;
    logic [4:0]  mc_issue_addr;
    logic        dec_valid;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic        dec_we;
    logic [4:0]  dec_dst;
    logic        stall;
    logic        RW;
    logic [4:0]  DA;
    logic [31:0] BUS_D;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    rf_write_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_stall      (wb_stall),
        .mc_valid      (mc_valid),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .mc_ready      (mc_ready),
        .mc_issue      (mc_issue),
        .mc_issue_addr (mc_issue_addr),
        .dec_valid     (dec_valid),
        .AA            (AA),
        .BA            (BA),
        .dec_we        (dec_we),
        .dec_dst       (dec_dst),
        .stall         (stall),
        .RW            (RW),
        .DA            (DA),
        .BUS_D         (BUS_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected register file writes.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every asserted write must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            $display("[TB] FAIL missed_write: no write seen at cycle %0d, expected r%0d=0x%0h",
                     exp_q[0].cyc, exp_q[0].addr, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (RW === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_write: got r%0d=0x%0h at cycle %0d, expected no write",
                         DA, BUS_D, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.addr == DA && e.data == BUS_D)
                    passes++;
                else
                    $display("[TB] FAIL write: got r%0d=0x%0h at cycle %0d, expected r%0d=0x%0h at cycle %0d",
                             DA, BUS_D, cyc, e.addr, e.data, e.cyc);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                 input logic iv, input logic [4:0] ia);
        wb_valid      = wv;
        wb_addr       = wa;
        wb_data       = wd;
        mc_valid      = mv;
        mc_addr       = ma;
        mc_data       = md;
        mc_issue      = iv;
        mc_issue_addr = ia;
    endtask

    task automatic setDecode(input logic dv, input logic [4:0] a, input logic [4:0] b,
                             input logic we, input logic [4:0] dst);
        dec_valid = dv;
        AA        = a;
        BA        = b;
        dec_we    = we;
        dec_dst   = dst;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc  = cyc;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atSample();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        setDecode(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // Requests during reset must not reach the outputs.
        applyStimulus(1, 3, 32'h99, 1, 4, 32'h98, 0, 0);
        setDecode(1, 5, 5, 0, 0);
        nextCycle();
        atSample();
        checkOutput("reset_rw", RW, 0);
        checkOutput("reset_da", DA, 0);
        checkOutput("reset_bus_d", BUS_D, 0);
        checkOutput("reset_mc_ready", mc_ready, 0);
        checkOutput("reset_wb_stall", wb_stall, 0);
        checkOutput("reset_stall", stall, 0);

        nextCycle();
        rst_n = 1'b1;
        idle();
        atSample();
        checkOutput("ready_after_reset", mc_ready, 1);

        // WB write with empty FIFO goes straight through.
        nextCycle();
        applyStimulus(1, 3, 32'h11, 0, 0, 0, 0, 0);
        expectWrite(3, 32'h11);
        atSample();
        checkOutput("wb_direct_stall", wb_stall, 0);

        // MC issue to r5, then hazard on AA/BA until the result drains.
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 5, 32'hAB, 0, 0);
        setDecode(1, 5, 0, 0, 0);
        atSample();
        checkOutput("raw_aa_stall", stall, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        setDecode(1, 0, 5, 0, 0);
        expectWrite(5, 32'hAB);
        atSample();
        checkOutput("raw_ba_stall", stall, 1);
        nextCycle();
        atSample();
        checkOutput("stall_cleared", stall, 0);

        // Starvation: head r7 loses to WB four times, then drains and stalls WB.
        nextCycle();
        setDecode(0, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'h22, 1, 7, 32'h77, 1, 7);
        expectWrite(2, 32'h22);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1, 2, 32'h23 + i, 0, 0, 0, 0, 0);
            setDecode(1, 0, 0, 1, 7);
            expectWrite(2, 32'h23 + i);
            atSample();
            checkOutput("wb_wins_stall", wb_stall, 0);
            if (i == 0) checkOutput("waw_stall", stall, 1);
        end
        nextCycle();
        applyStimulus(1, 2, 32'h27, 0, 0, 0, 0, 0);
        expectWrite(7, 32'h77);
        atSample();
        checkOutput("starved_wb_stall", wb_stall, 1);
        nextCycle();
        expectWrite(2, 32'h27);
        atSample();
        checkOutput("wb_retry_stall", wb_stall, 0);
        checkOutput("waw_cleared", stall, 0);

        // FIFO full back-pressure and refill after one pop.
        nextCycle();
        setDecode(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h31, 1, 8, 32'h88, 0, 0);
        expectWrite(1, 32'h31);
        nextCycle();
        applyStimulus(1, 1, 32'h32, 1, 9, 32'h99, 0, 0);
        expectWrite(1, 32'h32);
        atSample();
        checkOutput("ready_one_entry", mc_ready, 1);
        nextCycle();
        applyStimulus(1, 1, 32'h33, 1, 10, 32'hAA, 1, 0);
        setDecode(1, 0, 0, 0, 0);
        expectWrite(1, 32'h33);
        atSample();
        checkOutput("ready_full", mc_ready, 0);
        checkOutput("issue_full_stall", stall, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 10, 32'hAA, 0, 0);
        setDecode(0, 0, 0, 0, 0);
        expectWrite(8, 32'h88);
        atSample();
        checkOutput("ready_full_pop", mc_ready, 0);
        nextCycle();
        expectWrite(9, 32'h99);
        atSample();
        checkOutput("ready_after_pop", mc_ready, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        expectWrite(10, 32'hAA);

        // Writes and issues to r0 are discarded.
        nextCycle();
        applyStimulus(1, 0, 32'h55, 1, 0, 32'h66, 1, 0);
        atSample();
        checkOutput("r0_rw", RW, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        setDecode(1, 0, 0, 1, 0);
        atSample();
        checkOutput("r0_no_push", RW, 0);
        checkOutput("r0_not_busy", stall, 0);

        // Reset in the middle of a cycle with two entries queued.
        nextCycle();
        setDecode(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h41, 1, 4, 32'h44, 1, 4);
        expectWrite(1, 32'h41);
        nextCycle();
        applyStimulus(1, 1, 32'h42, 1, 6, 32'h46, 1, 6);
        expectWrite(1, 32'h42);
        nextCycle();
        applyStimulus(1, 1, 32'h43, 0, 0, 0, 0, 0);
        #2;
        checkOutput("rw_before_reset", RW, 1);
        checkOutput("full_before_reset", mc_ready, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rw", RW, 0);
        checkOutput("midreset_mc_ready", mc_ready, 0);
        atSample();
        nextCycle();
        rst_n = 1'b1;
        idle();
        setDecode(1, 4, 6, 1, 4);
        atSample();
        checkOutput("post_reset_busy", stall, 0);
        checkOutput("post_reset_ready", mc_ready, 1);
        checkOutput("post_reset_empty", RW, 0);
        nextCycle();
        atSample();
        checkOutput("post_reset_empty2", RW, 0);

        nextCycle();
        idle();
        atSample();
        checkOutput("pending_writes", exp_q.size(), 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port (RW/DA/BUS_D) of the 32x32 register file in the pipelined core.
- Shares that port between two writers:
  - the in-order pipeline writeback stage (WB);
  - a multi-cycle unit (MC, e.g. mult/div), whose results are buffered in a small FIFO.
- Keeps a per-register busy scoreboard for MC destinations and raises a decode stall on RAW/WAW hazards against pending MC writes.

Parameters:
- DEPTH, 2, MC result FIFO entries (power of two, >=2)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STARVE_LIM, 4, consecutive cycles a non-empty FIFO head may lose arbitration before it gets priority

Ports:
- clk in 1 system clock, rising edge
- rst_n in 1 asynchronous active-low reset
- wb_valid in 1 pipeline WB write request this cycle
- wb_addr in ADDR_W WB destination register
- wb_data in DATA_W WB write data
- wb_stall out 1 WB write not accepted this cycle; pipeline holds WB
- mc_valid in 1 MC result valid
- mc_addr in ADDR_W MC destination register
- mc_data in DATA_W MC result
- mc_ready out 1 FIFO can accept an MC result
- mc_issue in 1 decode issues an MC op this cycle
- mc_issue_addr in ADDR_W destination of the issued MC op
- dec_valid in 1 decode stage holds a valid instruction
- AA in ADDR_W decode source register A
- BA in ADDR_W decode source register B
- dec_we in 1 decode instruction writes a register
- dec_dst in ADDR_W decode destination register
- stall out 1 decode must hold (hazard)
- RW out 1 register file write enable
- DA out ADDR_W register file write address
- BUS_D out DATA_W register file write data

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: FIFO empty, busy vector all 0, age counter 0.
- Reset values of outputs (forced while rst_n=0): RW=0, DA=0, BUS_D=0, mc_ready=0, wb_stall=0, stall=0.
- Register 0: writes to address 0 are discarded from either source. They never assert RW, are never pushed, and never set busy. busy[0] is always 0.
- FIFO:
  - mc_ready = !full, derived from registered state only (no push-through when full).
  - Push when mc_valid && mc_ready && mc_addr!=0.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Age counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on every pop and whenever the FIFO is empty.
  - Saturates at STARVE_LIM.
- Write-port arbitration (combinational):
  - If age==STARVE_LIM and the FIFO is non-empty: drain the head (RW=1, DA=head.addr, BUS_D=head.data). Set wb_stall = wb_valid && wb_addr!=0.
  - Else if wb_valid && wb_addr!=0: RW=1, DA=wb_addr, BUS_D=wb_data, wb_stall=0.
  - Else if the FIFO is non-empty: drain the head.
  - Else: RW=0, DA=0, BUS_D=0.
- Write latency: the register file captures the write at the next rising edge. An MC result becomes visible in the register file no earlier than 1 cycle after it is pushed.
- Scoreboard:
  - busy[mc_issue_addr] is set on mc_issue (address != 0).
  - busy[head.addr] is cleared on the cycle the head drains to the register file, not on push.
  - Same-register set and clear in one cycle: set wins.
- Hazard stall (combinational): stall = dec_valid && (busy[AA] || busy[BA] || (dec_we && busy[dec_dst]) || (mc_issue && full)).
  - Because of this, a WB write and a pending MC write to the same register never coexist, and no WAW ordering is needed.
- Reset mid-operation: FIFO contents, busy bits and age are discarded immediately. The MC unit is reset by the same rst_n.

Decomposition:
- Shared core package holds ADDR_W, DATA_W and the REG_ZERO constant. A packed {addr,data} write-request typedef also goes there; the pipeline WB stage reuses it.
- One natural sub-module, rf_wr_fifo: parameterised DEPTH FIFO with full/empty outputs, head data and push/pop inputs.
- Arbiter, age counter and scoreboard stay in the top module.

Test Plan:
- Reset, then WB write r3=0x11 with the FIFO empty -> same cycle RW=1, DA=3, BUS_D=0x11, wb_stall=0.
- mc_issue r5; decode reads AA=5 -> stall=1. MC returns r5=0xAB with no WB traffic -> RW=1, DA=5 next cycle, busy[5] clears, stall drops the following cycle.
- Simultaneous WB r2=0x22 and FIFO head r7=0x77 -> WB wins, head stays. Keep WB busy for 4 cycles -> on the 5th cycle DA=7, BUS_D=0x77, wb_stall=1.
- Push 2 MC results with WB busy -> mc_ready=0. A third mc_valid is held. One pop -> mc_ready=1 and the push is accepted.
- Write requests to r0 from WB and MC -> RW never asserts, FIFO count is unchanged, busy[0]=0.
- Two entries queued and r4, r6 busy; assert rst_n=0 mid-cycle -> RW=0 and mc_ready=0 immediately. After release, the FIFO is empty and busy is all 0.
